mem_dma: RTL and testbench

- Block-copy engine that acts as the initiator on the single-port RAM interface: it drives write, addr and write data, and consumes the combinational read data.
- Sits beside the multicycle MIPS core as a memory-to-memory copy helper. Arbitration with the core is external: the core must not drive the RAM while busy=1.
- Copies len words from src to dst in ascending order, 2 cycles per word.

---
 rtl/mem_dma_if.sv | 36 +++
 rtl/mem_dma.sv | 203 ++++++++++++++++++++
 tb/tb_mem_dma.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_if.sv
// ----------------------------------------------------------------------------
// mem_dma_if : single-port RAM bus between an initiator and the RAM.
//
// Signals
//   memWrite  initiator -> RAM  write enable
//   memAddr   initiator -> RAM  word address
//   memWData  initiator -> RAM  write data
//   memRData  RAM -> initiator  read data, combinational from memAddr
//
// Modports
//   master : the initiator side (mem_dma)
//   slave  : the RAM side
// ----------------------------------------------------------------------------
interface mem_dma_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [WIDTH-1:0]      memWData;
    logic [WIDTH-1:0]      memRData;

    modport master (
        output memWrite,
        output memAddr,
        output memWData,
        input  memRData
    );

    modport slave (
        input  memWrite,
        input  memAddr,
        input  memWData,
        output memRData
    );
endinterface

// File: rtl/mem_dma.sv
// ----------------------------------------------------------------------------
// mem_dma : block-copy engine acting as initiator on the single-port RAM.
//
// Copies len words from src to dst in ascending order. Each word takes a READ
// cycle (source word captured into data_q) followed by a WRITE cycle (data_q
// written to destination). Addresses wrap modulo 2^ADDR_WIDTH. A DONE cycle
// pulses done once, then the engine returns to IDLE. count holds the number
// of words written until the next accepted start.
//
// Optional build macro: MEM_DMA_FILL_EN
//   Adds fill / fillData inputs. With fill=1 at start, READ is skipped and
//   fillData is written on consecutive cycles (one cycle per word).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; aborts any copy at once
//   start        copy request, sampled only in IDLE
//   src, dst     source / destination base word addresses (latched at start)
//   len          word count 0..2^ADDR_WIDTH (latched at start)
//   fill         (MEM_DMA_FILL_EN only) fill mode select, latched at start
//   fillData     (MEM_DMA_FILL_EN only) fill pattern, latched at start
//   busy         high in READ and WRITE
//   done         one-cycle completion pulse
//   count        words written so far in the current or last transfer
//   dbg_state_o  current FSM state (debug)
//   mem          RAM bus, master side
//
// Handshake: start is a level request accepted on the first rising edge on
// which the engine is IDLE; there is no back-pressure and no queueing, so a
// request seen in any other state is dropped.
// ----------------------------------------------------------------------------
module mem_dma #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef MEM_DMA_FILL_EN
    input  logic                  fill,
    input  logic [WIDTH-1:0]      fillData,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic [1:0]            dbg_state_o,
    mem_dma_if.master             mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  fill_mode;

    // count doubles as the word index i: both clear at start and step on
    // every WRITE, so one register serves both roles.
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH:0]   count_inc;

    assign idx       = count_q[ADDR_WIDTH-1:0];
    assign count_inc = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef MEM_DMA_FILL_EN
    logic fill_q, fill_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (state_q == S_IDLE && start) begin
            fill_d = fill;
        end
    end

    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    count_d = '0;
`ifdef MEM_DMA_FILL_EN
                    // Fill data is parked in the data register so the WRITE
                    // path is identical for copy and fill.
                    if (fill) begin
                        data_d = fillData;
                    end
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (fill) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
`else
                    state_d = (len == '0) ? S_DONE : S_READ;
`endif
                end
            end
            S_READ: begin
                data_d  = mem.memRData;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                count_d = count_inc;
                if (count_inc == len_q) begin
                    state_d = S_DONE;
                end else if (fill_mode) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registered state, so memWrite is
    // glitch-free and drops asynchronously with reset.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        mem.memWrite = 1'b0;
        mem.memAddr  = '0;
        unique case (state_q)
            S_READ: begin
                busy        = 1'b1;
                mem.memAddr = src_q + idx;
            end
            S_WRITE: begin
                busy         = 1'b1;
                mem.memWrite = 1'b1;
                mem.memAddr  = dst_q + idx;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mem.memWData = data_q;
    assign count        = count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_dma.sv
// ----------------------------------------------------------------------------
// tb_mem_dma : self-checking bench for mem_dma.
//
// A behavioural RAM sits on the slave side of the bus. At each accepted start
// the bench expands the transfer into the cycle-by-cycle sequence the engine
// must produce (read/write addresses, write data, count, done) using a plain
// ascending copy over a shadow memory, and a compare process checks every
// cycle against it. Hand-computed literals pin the model on the key cases.
// ----------------------------------------------------------------------------
module tb_mem_dma;
    localparam int W     = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int REC_W = W + 2 * AW + 4;

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src   = '0;
    logic [AW-1:0] dst   = '0;
    logic [AW:0]   len   = '0;
`ifdef MEM_DMA_FILL_EN
    logic          fill      = 1'b0;
    logic [W-1:0]  fill_data = '0;
`endif
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    mem_dma_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    mem_dma #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
`ifdef MEM_DMA_FILL_EN
        .fill       (fill),
        .fillData   (fill_data),
`endif
        .busy       (busy),
        .done       (done),
        .count      (count),
        .dbg_state_o(dbg_state),
        .mem        (bus)
    );

    // ---------------- RAM ----------------
    logic [W-1:0]  ram     [DEPTH];
    logic [W-1:0]  exp_mem [DEPTH];
    logic [W-1:0]  sim_mem [DEPTH];
    logic          init_en   = 1'b0;
    logic          poke_en   = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [W-1:0]  poke_data = '0;

    function automatic logic [W-1:0] pat(input int i);
        return W'(i * 3 + 7);
    endfunction

    assign bus.memRData = ram[bus.memAddr];

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (bus.memWrite) begin
            ram[bus.memAddr] <= bus.memWData;
        end
    end

    // ---------------- scoreboard ----------------
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] r;
    logic [AW:0]      exp_count_last = '0;
    int               n_vec  = 0;
    int               n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic b, input logic d, input logic w,
                                                input logic [AW:0] c, input logic [AW-1:0] a,
                                                input logic [W-1:0] wd);
        return {b, d, w, c, a, wd};
    endfunction

    always @(negedge clk) begin
        if (init_en) begin
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
        end
        if (poke_en) exp_mem[poke_addr] = poke_data;
        if (!reset) begin
            exp_q.delete();
            exp_count_last = '0;
            chk("rst_busy",  busy,         0);
            chk("rst_done",  done,         0);
            chk("rst_count", count,        0);
            chk("rst_we",    bus.memWrite, 0);
            chk("rst_addr",  bus.memAddr,  0);
            chk("rst_wdata", bus.memWData, 0);
        end else if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("cyc_busy",  busy,         r[REC_W-1]);
            chk("cyc_done",  done,         r[REC_W-2]);
            chk("cyc_we",    bus.memWrite, r[REC_W-3]);
            chk("cyc_count", count,        r[W+2*AW:W+AW]);
            chk("cyc_addr",  bus.memAddr,  r[W+AW-1:W]);
            if (r[REC_W-3]) begin
                chk("cyc_wdata", bus.memWData, r[W-1:0]);
                exp_mem[r[W+AW-1:W]] = r[W-1:0];
            end
            if (r[REC_W-2]) exp_count_last = r[W+2*AW:W+AW];
        end else begin
            chk("idle_busy",  busy,         0);
            chk("idle_done",  done,         0);
            chk("idle_we",    bus.memWrite, 0);
            chk("idle_addr",  bus.memAddr,  0);
            chk("idle_count", count,        exp_count_last);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_init();
        @(posedge clk); #1 init_en = 1'b1;
        @(posedge clk); #1 init_en = 1'b0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [W-1:0] v);
        @(posedge clk); #1 poke_en = 1'b1; poke_addr = a; poke_data = v;
        @(posedge clk); #1 poke_en = 1'b0;
    endtask

    task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [AW:0] l, input bit f, input logic [W-1:0] fd);
        logic [AW-1:0] as, ad;
        logic [W-1:0]  v;
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
`ifdef MEM_DMA_FILL_EN
        fill = f; fill_data = fd;
`endif
        @(posedge clk);
        // Expected sequence: plain ascending copy over a shadow memory.
        for (int i = 0; i < DEPTH; i++) sim_mem[i] = exp_mem[i];
        for (int k = 0; k < int'(l); k++) begin
            as = s + AW'(k);
            ad = d + AW'(k);
            if (f) begin
                v = fd;
            end else begin
                v = sim_mem[as];
                exp_q.push_back(mk_rec(1'b1, 1'b0, 1'b0, (AW+1)'(k), as, '0));
            end
            sim_mem[ad] = v;
            exp_q.push_back(mk_rec(1'b1, 1'b0, 1'b1, (AW+1)'(k), ad, v));
        end
        exp_q.push_back(mk_rec(1'b0, 1'b1, 1'b0, l, '0, '0));
        #1;
        start = 1'b0;
        // Inputs after acceptance must have no effect.
        src = AW'($urandom_range(0, DEPTH-1));
        dst = AW'($urandom_range(0, DEPTH-1));
        len = (AW+1)'($urandom_range(0, DEPTH));
`ifdef MEM_DMA_FILL_EN
        fill = 1'b0; fill_data = $urandom;
`endif
    endtask

    task automatic wait_done(input string nm, input int exp_lat, input int exp_busy,
                             input int exp_we);
        int n, b, dc, lat, wc;
        n = 0; b = 0; dc = 0; lat = -1; wc = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (busy) b++;
            if (bus.memWrite) wc++;
            if (done) begin
                dc++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n > lat) break;
        end
        if (lat < 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 3000 cycles", nm);
        end else begin
            chk({nm, "_latency"},  lat, exp_lat);
            chk({nm, "_busy_cyc"}, b,   exp_busy);
            chk({nm, "_done_cnt"}, dc,  1);
            chk({nm, "_we_cyc"},   wc,  exp_we);
        end
    endtask

    task automatic check_mem(input string nm);
        int bad, first;
        bad = 0; first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_mem: got %0d bad words (first at %0h) expected 0", nm, bad, first);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pulse_init();
        #2;
        chk("por_busy",  busy,         0);
        chk("por_done",  done,         0);
        chk("por_count", count,        0);
        chk("por_we",    bus.memWrite, 0);
        chk("por_addr",  bus.memAddr,  0);
        chk("por_wdata", bus.memWData, 0);
        @(negedge clk); #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic copy 0x10..0x13 -> 0x20..0x23
        for (int i = 0; i < 4; i++) poke(AW'(16 + i), W'(i + 1));
        start_copy(10'h010, 10'h020, 11'd4, 1'b0, '0);
        wait_done("copy4", 9, 8, 4);
        #1;
        chk("copy4_ram20", ram[10'h020], 32'd1);
        chk("copy4_ram21", ram[10'h021], 32'd2);
        chk("copy4_ram22", ram[10'h022], 32'd3);
        chk("copy4_ram23", ram[10'h023], 32'd4);
        chk("copy4_count", count, 11'd4);
        check_mem("copy4");

        // len = 0
        start_copy(10'h030, 10'h050, 11'd0, 1'b0, '0);
        wait_done("len0", 1, 0, 0);
        #1;
        chk("len0_count", count, 11'd0);
        check_mem("len0");

        // Address wrap on the source side
        poke(10'h3FE, 32'h111); poke(10'h3FF, 32'h222);
        poke(10'h000, 32'h333); poke(10'h001, 32'h444);
        start_copy(10'h3FE, 10'h100, 11'd4, 1'b0, '0);
        wait_done("wrap", 9, 8, 4);
        #1;
        chk("wrap_ram100", ram[10'h100], 32'h111);
        chk("wrap_ram101", ram[10'h101], 32'h222);
        chk("wrap_ram102", ram[10'h102], 32'h333);
        chk("wrap_ram103", ram[10'h103], 32'h444);
        check_mem("wrap");

        // Overlap dst > src replicates
        poke(10'h000, 32'hA); poke(10'h001, 32'hB); poke(10'h002, 32'hC);
        start_copy(10'h000, 10'h001, 11'd2, 1'b0, '0);
        wait_done("ovl", 5, 4, 2);
        #1;
        chk("ovl_ram0", ram[0], 32'hA);
        chk("ovl_ram1", ram[1], 32'hA);
        chk("ovl_ram2", ram[2], 32'hA);
        check_mem("ovl");

        // dst == src
        start_copy(10'h020, 10'h020, 11'd3, 1'b0, '0);
        wait_done("same", 7, 6, 3);
        #1;
        chk("same_ram21", ram[10'h021], 32'd2);
        check_mem("same");

        // Asynchronous reset in the middle of a WRITE
        for (int i = 0; i < 4; i++) poke(AW'(96 + i), W'(32'h60 + i));
        start_copy(10'h060, 10'h070, 11'd4, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_we", bus.memWrite, 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_we",    bus.memWrite, 0);
        chk("abort_busy",  busy,         0);
        chk("abort_count", count,        0);
        chk("abort_done",  done,         0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_ram70", ram[10'h070], 32'h60);
        chk("abort_ram71", ram[10'h071], pat(32'h71));
        check_mem("abort");
        start_copy(10'h060, 10'h070, 11'd4, 1'b0, '0);
        wait_done("after_abort", 9, 8, 4);
        #1;
        chk("after_abort_ram73", ram[10'h073], 32'h63);
        check_mem("after_abort");

`ifdef MEM_DMA_FILL_EN
        // Fill mode
        start_copy(10'h000, 10'h040, 11'd3, 1'b1, 32'hDEADBEEF);
        wait_done("fill", 4, 3, 3);
        #1;
        chk("fill_ram40", ram[10'h040], 32'hDEADBEEF);
        chk("fill_ram41", ram[10'h041], 32'hDEADBEEF);
        chk("fill_ram42", ram[10'h042], 32'hDEADBEEF);
        chk("fill_count", count, 11'd3);
        check_mem("fill");
`endif

        // Whole memory, overlapping destination
        start_copy(10'h000, 10'h200, 11'd1024, 1'b0, '0);
        wait_done("full", 2049, 2048, 1024);
        #1;
        chk("full_count", count, 11'd1024);
        check_mem("full");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
